univ_shift_reg: RTL

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg_pkg.sv | 7 +
 rtl/univ_shift_reg.sv | 58 +++++
 2 files changed

// File: rtl/univ_shift_reg_pkg.sv
// univ_shift_reg_pkg: shared mode/state encodings and parameter defaults for univ_shift_reg
package univ_shift_reg_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;
  typedef enum logic [1:0] {M_HOLD = 2'b00, M_SR = 2'b01, M_SL = 2'b10, M_LOAD = 2'b11} mode_t;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_SHIFT = 2'b01, S_DONE = 2'b10} state_t;
endpackage

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: multi-cycle universal shift register with hold/shift-right/shift-left/load and done pulse
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             r,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [CNT_W-1:0] cnt,
  input  logic             sr_in,
  input  logic             sl_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             so,
  output logic             busy,
  output logic             done
);
  state_t state, state_nx;
  mode_t lmode, lmode_nx, eff;
  logic [CNT_W-1:0] rem, rem_nx;
  logic [WIDTH-1:0] q_nx;
  logic so_nx, idle_go, shift_go, shift_en;
  always_ff @(posedge clk or negedge r)
    if (!r) begin
      state <= S_IDLE;
      lmode <= M_HOLD;
      rem   <= '0;
      q     <= '0;
      so    <= 1'b0;
    end else begin
      state <= state_nx;
      lmode <= lmode_nx;
      rem   <= rem_nx;
      q     <= q_nx;
      so    <= so_nx;
    end
  // the start edge uses the live mode; SHIFT cycles use the latched copy
  always_comb begin
    idle_go  = (state == S_IDLE) && start;
    eff      = idle_go ? mode_t'(mode) : lmode;
    shift_go = idle_go && (eff == M_SR || eff == M_SL) && (cnt != '0);
    shift_en = shift_go || (state == S_SHIFT);
    q_nx     = !shift_en ? ((idle_go && eff == M_LOAD) ? d : q) :
               (eff == M_SR) ? {sr_in, q[WIDTH-1:1]} : {q[WIDTH-2:0], sl_in};
    so_nx    = !shift_en ? so : (eff == M_SR) ? q[0] : q[WIDTH-1];
    rem_nx   = shift_go ? cnt - CNT_W'(1) : (state == S_SHIFT) ? rem - CNT_W'(1) : rem;
    lmode_nx = idle_go ? eff : lmode;
    state_nx = (state == S_IDLE) ? ((shift_go && cnt != CNT_W'(1)) ? S_SHIFT : idle_go ? S_DONE : S_IDLE) :
               (state == S_SHIFT) ? ((rem == CNT_W'(1)) ? S_DONE : S_SHIFT) : S_IDLE;
  end
  assign qn   = ~q;
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
endmodule
